// File: rtl/mem_2k_arbiter.sv
// Round-robin arbiter sharing one simple-dual-port RAM between two writers
// and two readers, returning read data to the issuing client.
module mem_2k_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              aclr,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_gnt,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_gnt,
  input  logic              rd0_req,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic              rd0_gnt,
  output logic              rd0_rvalid,
  input  logic              rd1_req,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              rd1_gnt,
  output logic              rd1_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_wraddress,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_rdaddress,
  input  logic [DATA_W-1:0] mem_q
);

  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [ADDR_W-1:0] r_wraddr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_rdaddr;
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_id;

  logic              w_wr_sel;
  logic              w_wr_any;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_rd_sel;
  logic              w_rd_any;
  logic              w_rd_stall;
  logic [ADDR_W-1:0] w_rd_addr;

  // sel=1 picks client 1; pointer breaks ties only when both request
  assign w_wr_sel  = wr1_req & (~wr0_req | r_wr_ptr);
  assign w_wr_any  = (wr0_req | wr1_req) & ~aclr;
  assign w_wr_addr = w_wr_sel ? wr1_addr : wr0_addr;
  assign w_wr_data = w_wr_sel ? wr1_data : wr0_data;

  assign wr0_gnt       = w_wr_any & ~w_wr_sel;
  assign wr1_gnt       = w_wr_any & w_wr_sel;
  assign mem_wren      = w_wr_any;
  assign mem_wraddress = w_wr_any ? w_wr_addr : r_wraddr;
  assign mem_data      = w_wr_any ? w_wr_data : r_wdata;

  assign w_rd_sel  = rd1_req & (~rd0_req | r_rd_ptr);
  assign w_rd_addr = w_rd_sel ? rd1_addr : rd0_addr;
  // same-address collision with a write: hold the read off one cycle
  assign w_rd_stall = mem_wren & (w_rd_addr == mem_wraddress);
  assign w_rd_any   = (rd0_req | rd1_req) & ~aclr & ~w_rd_stall;

  assign rd0_gnt       = w_rd_any & ~w_rd_sel;
  assign rd1_gnt       = w_rd_any & w_rd_sel;
  assign mem_rdaddress = w_rd_any ? w_rd_addr : r_rdaddr;

  assign rd0_rvalid = r_vld[RD_LAT-1] & ~r_id[RD_LAT-1];
  assign rd1_rvalid = r_vld[RD_LAT-1] & r_id[RD_LAT-1];
  assign rd_rdata   = mem_q;

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_wr_ptr <= 1'b0;
      r_wraddr <= '0;
      r_wdata  <= '0;
    end else if (w_wr_any) begin
      r_wr_ptr <= ~w_wr_sel;
      r_wraddr <= w_wr_addr;
      r_wdata  <= w_wr_data;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_rd_ptr <= 1'b0;
      r_rdaddr <= '0;
    end else if (w_rd_any) begin
      r_rd_ptr <= ~w_rd_sel;
      r_rdaddr <= w_rd_addr;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_vld <= '0;
      r_id  <= '0;
    end else begin
      r_vld[0] <= w_rd_any;
      r_id[0]  <= w_rd_sel;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_2k_arbiter.sv
// Directed bench for mem_2k_arbiter with a behavioural two-stage RAM.
module tb_mem_2k_arbiter;

  logic        clock = 1'b0;
  logic        aclr;
  logic        wr0_req, wr1_req, rd0_req, rd1_req;
  logic [10:0] wr0_addr, wr1_addr, rd0_addr, rd1_addr;
  logic [63:0] wr0_data, wr1_data;
  logic        wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt;
  logic        rd0_rvalid, rd1_rvalid;
  logic [63:0] rd_rdata;
  logic        mem_wren;
  logic [10:0] mem_wraddress, mem_rdaddress;
  logic [63:0] mem_data, mem_q;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] ram [0:2047];
  logic [10:0] r_ra;
  logic [63:0] r_q;
  logic        pl_en = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [63:0] pl_data = '0;

  always #5 clock = ~clock;

  // registered address, registered output: two clocks grant-to-data
  always @(posedge clock) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_wren) ram[mem_wraddress] <= mem_data;
    r_ra <= mem_rdaddress;
    r_q  <= ram[r_ra];
  end
  assign mem_q = r_q;

  mem_2k_arbiter dut (
    .clock(clock), .aclr(aclr),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .wr1_gnt(wr1_gnt),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
    .rd0_rvalid(rd0_rvalid),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
    .rd1_rvalid(rd1_rvalid),
    .rd_rdata(rd_rdata),
    .mem_wren(mem_wren), .mem_wraddress(mem_wraddress),
    .mem_data(mem_data), .mem_rdaddress(mem_rdaddress),
    .mem_q(mem_q)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [63:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    aclr = 1'b1;
    @(negedge clock);
    aclr = 1'b0;
  endtask

  initial begin
    aclr = 1'b1;
    wr0_req = 0; wr1_req = 0; rd0_req = 0; rd1_req = 0;
    wr0_addr = '0; wr1_addr = '0; rd0_addr = '0; rd1_addr = '0;
    wr0_data = '0; wr1_data = '0;

    preload(11'h100, 64'hA);
    preload(11'h200, 64'hB);
    preload(11'h3FF, 64'h11);
    preload(11'h000, 64'hDEAD0000);

    // requests during reset must not be granted
    cyc(); wr0_req = 1; rd1_req = 1; settle();
    chk("rst_wr0_gnt", wr0_gnt, 0);
    chk("rst_rd1_gnt", rd1_gnt, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_rvalid", {rd0_rvalid, rd1_rvalid}, 0);
    wr0_req = 0; rd1_req = 0;

    // single write then read back by rd1
    cyc(); aclr = 0;
    cyc(); wr0_req = 1; wr0_addr = 11'h005;
    wr0_data = 64'h0123456789ABCDEF; settle();
    chk("t1_wr0_gnt", wr0_gnt, 1);
    chk("t1_wraddr", mem_wraddress, 11'h005);
    chk("t1_wdata", mem_data, 64'h0123456789ABCDEF);
    cyc(); wr0_req = 0; settle();
    chk("t1_idle_wren", mem_wren, 0);
    chk("t1_idle_wraddr", mem_wraddress, 11'h005);
    cyc(); rd1_req = 1; rd1_addr = 11'h005; settle();
    chk("t1_rd1_gnt", rd1_gnt, 1);
    chk("t1_rdaddr", mem_rdaddress, 11'h005);
    cyc(); rd1_req = 0; settle();
    chk("t1_rv_early", {rd0_rvalid, rd1_rvalid}, 2'b00);
    cyc(); settle();
    chk("t1_rd1_rvalid", rd1_rvalid, 1);
    chk("t1_rd0_rvalid", rd0_rvalid, 0);
    chk("t1_rdata", rd_rdata, 64'h0123456789ABCDEF);
    cyc(); settle();
    chk("t1_rv_after", {rd0_rvalid, rd1_rvalid}, 2'b00);

    // two writers contending alternate
    pulse_reset();
    wr0_req = 1; wr0_addr = 11'h010; wr0_data = 64'hD0;
    wr1_req = 1; wr1_addr = 11'h011; wr1_data = 64'hD1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("t2_wr0_gnt%0d", i), wr0_gnt, (i % 2 == 0));
      chk($sformatf("t2_wr1_gnt%0d", i), wr1_gnt, (i % 2 == 1));
      chk($sformatf("t2_wraddr%0d", i), mem_wraddress,
          (i % 2 == 0) ? 11'h010 : 11'h011);
      cyc();
    end
    wr0_req = 0; wr1_req = 0;

    // two readers streaming, no bubbles
    rd0_addr = 11'h100; rd1_addr = 11'h200;
    for (int i = 0; i < 8; i++) begin
      cyc();
      rd0_req = (i < 6); rd1_req = (i < 6);
      settle();
      if (i < 6) begin
        chk($sformatf("t3_rd0_gnt%0d", i), rd0_gnt, (i % 2 == 0));
        chk($sformatf("t3_rd1_gnt%0d", i), rd1_gnt, (i % 2 == 1));
      end
      if (i >= 2) begin
        chk($sformatf("t3_rv0_%0d", i), rd0_rvalid, (i % 2 == 0));
        chk($sformatf("t3_rv1_%0d", i), rd1_rvalid, (i % 2 == 1));
        chk($sformatf("t3_data%0d", i), rd_rdata,
            (i % 2 == 0) ? 64'hA : 64'hB);
      end else begin
        chk($sformatf("t3_rv_none%0d", i),
            {rd0_rvalid, rd1_rvalid}, 2'b00);
      end
    end
    rd0_req = 0; rd1_req = 0;

    // write/read collision on 0x3FF
    cyc();
    wr1_req = 1; wr1_addr = 11'h3FF; wr1_data = 64'h55;
    rd0_req = 1; rd0_addr = 11'h3FF; settle();
    chk("t4_wr1_gnt", wr1_gnt, 1);
    chk("t4_rd0_stall", rd0_gnt, 0);
    cyc(); wr1_req = 0; settle();
    chk("t4_rd0_gnt", rd0_gnt, 1);
    chk("t4_rdaddr", mem_rdaddress, 11'h3FF);
    cyc(); rd0_req = 0; settle();
    chk("t4_rv_early", rd0_rvalid, 0);
    cyc(); settle();
    chk("t4_rd0_rvalid", rd0_rvalid, 1);
    chk("t4_rdata", rd_rdata, 64'h55);

    // reset while a read is in flight
    cyc();
    rd0_req = 1; rd0_addr = 11'h100;
    wr0_req = 1; wr0_addr = 11'h030; wr0_data = 64'h30; settle();
    chk("t5_rd0_gnt", rd0_gnt, 1);
    chk("t5_wr0_gnt", wr0_gnt, 1);
    cyc(); rd0_req = 0; wr0_req = 0; aclr = 1; settle();
    chk("t5_rv_in_rst", {rd0_rvalid, rd1_rvalid}, 2'b00);
    cyc(); aclr = 0; settle();
    chk("t5_rv_post0", {rd0_rvalid, rd1_rvalid}, 2'b00);
    cyc(); settle();
    chk("t5_rv_post1", {rd0_rvalid, rd1_rvalid}, 2'b00);
    cyc();
    wr0_req = 1; wr0_addr = 11'h020; wr0_data = 64'h20;
    wr1_req = 1; wr1_addr = 11'h021; wr1_data = 64'h21;
    rd0_req = 1; rd0_addr = 11'h100;
    rd1_req = 1; rd1_addr = 11'h200; settle();
    chk("t5_wr_first", {wr0_gnt, wr1_gnt}, 2'b10);
    chk("t5_rd_first", {rd0_gnt, rd1_gnt}, 2'b10);
    cyc();
    wr0_req = 0; wr1_req = 0; rd0_req = 0; rd1_req = 0;
    cyc(); cyc();

    // top of address range, no aliasing onto 0x000
    cyc();
    wr0_req = 1; wr0_addr = 11'h7FF;
    wr0_data = 64'hFEEDFACECAFEBABE; settle();
    chk("t6_wr0_gnt", wr0_gnt, 1);
    chk("t6_wraddr", mem_wraddress, 11'h7FF);
    cyc(); wr0_req = 0;
    rd0_req = 1; rd0_addr = 11'h7FF; settle();
    chk("t6_rd0_gnt", rd0_gnt, 1);
    chk("t6_rdaddr", mem_rdaddress, 11'h7FF);
    cyc(); rd0_req = 0;
    rd1_req = 1; rd1_addr = 11'h000; settle();
    chk("t6_rd1_gnt", rd1_gnt, 1);
    cyc(); rd1_req = 0; settle();
    chk("t6_rv0", rd0_rvalid, 1);
    chk("t6_data_top", rd_rdata, 64'hFEEDFACECAFEBABE);
    cyc(); settle();
    chk("t6_rv1", rd1_rvalid, 1);
    chk("t6_data_zero", rd_rdata, 64'hDEAD0000);

    cyc();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
